// File: rtl/mul_arb_pkg.sv
// rtl/mul_arb_pkg.sv - shared constants and FSM state type for the 25519 multiplier arbiter
package mul_arb_pkg;

    localparam int FE_W     = 255;
    localparam int NREQ_DEF = 4;

    // p = 2^255 - 19
    localparam logic [FE_W-1:0] P = {{(FE_W-5){1'b1}}, 5'b01101};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mul_arb_25519_rr_pick.sv
// rtl/mul_arb_25519_rr_pick.sv - combinational round-robin pick starting after last_grant
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] pending,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        pos   = '0;
        // Visit last_grant+1 .. last_grant+NREQ modulo NREQ; first pending wins.
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, last_grant} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            pos = sum[IW-1:0];
            if (!found && pending[pos]) begin
                found      = 1'b1;
                idx        = pos;
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_arb_25519.sv
// rtl/mul_arb_25519.sv - shares one mod-p multiplier among NREQ requesters
// Define MUL_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mul_arb_25519
    import mul_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_start,
    input  logic [NREQ*FE_W-1:0] req_a,
    input  logic [NREQ*FE_W-1:0] req_b,
    output logic [NREQ-1:0]      req_done,
    output logic [FE_W-1:0]      res,
    output logic [NREQ-1:0]      req_busy,
    output logic                 m_start,
    output logic [FE_W-1:0]      m_a,
    output logic [FE_W-1:0]      m_b,
    input  logic [FE_W-1:0]      m_res,
    input  logic                 m_done,
    input  logic                 m_busy
);

    localparam int IW = $clog2(NREQ);

    state_t          state;
    logic [NREQ-1:0] pending;
    logic [IW-1:0]   g;
    logic [NREQ-1:0] clr;
    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   lg_sel;
    logic [FE_W-1:0] a_arr [NREQ];
    logic [FE_W-1:0] b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*FE_W +: FE_W];
        assign b_arr[i] = req_b[i*FE_W +: FE_W];
    end

`ifdef MUL_ARB_FIXED_PRIO_EN
    assign lg_sel = IW'(NREQ-1);
`else
    logic [IW-1:0] last_grant;
    assign lg_sel = last_grant;
`endif

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .pending    (pending),
        .last_grant (lg_sel),
        .grant      (pick_grant),
        .idx        (pick_idx)
    );

    // Completion clears the owner's pending bit and overrides a coincident restart.
    assign clr      = (state == S_WAIT && m_done) ? (NREQ'(1) << g) : '0;
    assign req_busy = pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pending  <= '0;
            g        <= '0;
            req_done <= '0;
            m_start  <= 1'b0;
            m_a      <= '0;
            m_b      <= '0;
            res      <= '0;
`ifndef MUL_ARB_FIXED_PRIO_EN
            last_grant <= IW'(NREQ-1);
`endif
        end else begin
            m_start  <= 1'b0;
            req_done <= '0;
            pending  <= (pending | req_start) & ~clr;
            case (state)
                S_IDLE: begin
                    if ((|pick_grant) && !m_busy) begin
                        state   <= S_WAIT;
                        g       <= pick_idx;
                        m_a     <= a_arr[pick_idx];
                        m_b     <= b_arr[pick_idx];
                        m_start <= 1'b1;
`ifndef MUL_ARB_FIXED_PRIO_EN
                        last_grant <= pick_idx;
`endif
                    end
                end
                S_WAIT: begin
                    if (m_done) begin
                        state    <= S_IDLE;
                        res      <= m_res;
                        req_done <= clr;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
